// File: rtl/inst_fetch_align.sv
// inst_fetch_align: returns the 16/32-bit RISC-V instruction at pc from a
// 2-entry direct-mapped buffer of 64-bit words. It refills the buffer over a
// req/gnt/rvalid port, and assembles instructions that straddle two words.
module inst_fetch_align #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              inst_valid,
    output logic              inst_comp,
    output logic [31:0]       inst,
    output logic              request,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata
);
    localparam int TAG_W = ADDR_W - 4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                  state, state_nx;
    logic                    mem_req_nx;
    logic [ADDR_W-1:0]       mem_addr_nx;

    logic [1:0]              vld;
    logic [1:0][TAG_W-1:0]   tag;
    logic [1:0][63:0]        data;
    logic                    drop;

    logic [ADDR_W-1:0]       l_addr, h_addr, miss_addr;
    logic                    l_idx, h_idx, l_hit, h_hit;
    logic [63:0]             l_word, h_word;
    logic [15:0]             hw0, hw1;
    logic                    hw0_comp, data_ok, miss;
    logic                    fill_we, fill_idx;
    logic                    unused_pc0;

    // pc[0] carries no information for halfword-aligned fetch
    assign unused_pc0 = pc[0];

    assign l_addr = {pc[ADDR_W-1:3], 3'b000};
    assign h_addr = l_addr + ADDR_W'(8);
    assign l_idx  = l_addr[3];
    assign h_idx  = h_addr[3];
    assign l_hit  = vld[l_idx] && (tag[l_idx] == l_addr[ADDR_W-1:4]);
    assign h_hit  = vld[h_idx] && (tag[h_idx] == h_addr[ADDR_W-1:4]);
    assign l_word = data[l_idx];
    assign h_word = data[h_idx];

    // Pick the first halfword at pc and the one after it (next word when at offset 6)
    always_comb begin
        hw0 = l_word[15:0];
        hw1 = l_word[31:16];
        case (pc[2:1])
            2'd0: begin hw0 = l_word[15:0];  hw1 = l_word[31:16]; end
            2'd1: begin hw0 = l_word[31:16]; hw1 = l_word[47:32]; end
            2'd2: begin hw0 = l_word[47:32]; hw1 = l_word[63:48]; end
            default: begin hw0 = l_word[63:48]; hw1 = h_word[15:0]; end
        endcase
    end

    assign hw0_comp = (hw0[1:0] != 2'b11);

    // The high word is only needed for a 32-bit instruction starting at offset 6
    assign data_ok   = (pc[2:1] != 2'd3 || hw0_comp) ? l_hit : (l_hit && h_hit);
    assign miss      = !data_ok;
    assign miss_addr = l_hit ? h_addr : l_addr;

    // A flush in this cycle hides bytes that the same edge is about to invalidate
    assign inst_valid = data_ok && !flush;
    assign inst_comp  = inst_valid && hw0_comp;
    assign inst       = !inst_valid ? 32'h0 :
                        hw0_comp    ? {16'h0, hw0} : {hw1, hw0};
    assign request    = (state != IDLE) || miss;

    assign fill_we  = (state == WAIT) && mem_rvalid;
    assign fill_idx = mem_addr[3];

    // FSM state and registered memory request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_nx;
            mem_req  <= mem_req_nx;
            mem_addr <= mem_addr_nx;
        end
    end

    // Next state; gnt/rvalid outside their own state are ignored
    always_comb begin
        state_nx    = state;
        mem_req_nx  = mem_req;
        mem_addr_nx = mem_addr;
        case (state)
            IDLE: begin
                if (miss && !flush) begin
                    state_nx    = REQ;
                    mem_req_nx  = 1'b1;
                    mem_addr_nx = miss_addr;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_nx   = WAIT;
                    mem_req_nx = 1'b0;
                end
            end
            WAIT: begin
                if (mem_rvalid) state_nx = IDLE;
            end
            default: begin
                state_nx   = IDLE;
                mem_req_nx = 1'b0;
            end
        endcase
    end

    // Valid bits and the drop marker for a fill that a flush has made stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            drop <= 1'b0;
        end else begin
            if (flush)
                vld <= '0;
            else if (fill_we && !drop)
                vld[fill_idx] <= 1'b1;
            if (state_nx == IDLE)
                drop <= 1'b0;
            else if (flush)
                drop <= 1'b1;
        end
    end

    // Fill data and tag; a fill overwrites the entry regardless of its contents
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data[fill_idx] <= mem_rdata;
            tag[fill_idx]  <= mem_addr[ADDR_W-1:4];
        end
    end
endmodule

// File: tb/tb_inst_fetch_align.sv
// Self-checking bench for inst_fetch_align: table of fetch vectors applied to a
// small memory responder, plus hand sequences for back-pressure, flush, reset.
module tb_inst_fetch_align;
    logic        clk, rst_n, flush;
    logic [63:0] pc;
    logic        inst_valid, inst_comp, request, mem_req;
    logic [31:0] inst;
    logic [63:0] mem_addr;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;

    inst_fetch_align #(.ADDR_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush),
        .inst_valid(inst_valid), .inst_comp(inst_comp), .inst(inst),
        .request(request), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: 32 words indexed by addr[7:3]
    logic [63:0] mem [32];
    int          gnt_delay = 0;
    int          rv_delay = 0;
    int          nreq = 0;
    logic [63:0] req_log [$];

    initial begin
        int gcnt, rcnt;
        logic pend;
        logic [63:0] raddr;
        gcnt = 0; rcnt = 0; pend = 1'b0; raddr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                mem_gnt = 1'b0; pend = 1'b0; gcnt = 0;
            end else begin
                if (mem_gnt) begin
                    mem_gnt = 1'b0; pend = 1'b1; rcnt = 0;
                end
                if (pend) begin
                    if (rcnt >= rv_delay) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem[raddr[7:3]];
                        pend = 1'b0;
                    end else rcnt++;
                end else if (mem_req) begin
                    if (gcnt >= gnt_delay) begin
                        mem_gnt = 1'b1;
                        raddr = mem_addr;
                        req_log.push_back(mem_addr);
                        nreq++;
                        gcnt = 0;
                    end else gcnt++;
                end
            end
        end
    end

    // Wait (bounded) for inst_valid; lat counts clock edges taken
    task automatic wait_valid(input int maxc, output int lat);
        lat = 0;
        #1;
        while (!inst_valid && lat < maxc) begin
            @(negedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        comp;
        int          reqs;
        int          lat;
        logic [63:0] a0;
        logic [63:0] a1;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, base, tot;
        foreach (mem[i]) mem[i] = '0;
        mem[0] = 64'h0000_4501_0010_0093;
        mem[2] = 64'h0513_1111_2222_3333;
        mem[3] = 64'h0003_00AA_0000_0040;
        mem[4] = 64'h4505_0000_0000_0297;
        mem[6] = 64'h0000_0000_0000_8082;
        mem[8] = 64'h0000_0000_0000_0013;

        //          pc      inst          comp reqs lat a0     a1
        tbl[0]  = '{64'h00, 32'h00100093, 1'b0, 1, 3, 64'h00, 64'h0};
        tbl[1]  = '{64'h04, 32'h00004501, 1'b1, 0, 0, 64'h00, 64'h0};
        tbl[2]  = '{64'h02, 32'h00000010, 1'b1, 0, 0, 64'h00, 64'h0};
        tbl[3]  = '{64'h16, 32'h00400513, 1'b0, 2, 6, 64'h10, 64'h18};
        tbl[4]  = '{64'h10, 32'h22223333, 1'b0, 0, 0, 64'h00, 64'h0};
        tbl[5]  = '{64'h26, 32'h00004505, 1'b1, 1, 3, 64'h20, 64'h0};
        tbl[6]  = '{64'h18, 32'h00000040, 1'b1, 0, 0, 64'h00, 64'h0};
        tbl[7]  = '{64'h01, 32'h00100093, 1'b0, 1, 3, 64'h00, 64'h0};
        tbl[8]  = '{64'h1E, 32'h02970003, 1'b0, 1, 3, 64'h20, 64'h0};
        tbl[9]  = '{64'h26, 32'h00004505, 1'b1, 0, 0, 64'h00, 64'h0};
        tbl[10] = '{64'h1C, 32'h000000AA, 1'b1, 0, 0, 64'h00, 64'h0};

        // Reset state
        rst_n = 1'b0; flush = 1'b0; pc = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_comp", inst_comp, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_request", request, 1'b1);
        rst_n = 1'b1;

        // Table-driven fetch vectors
        for (int v = 0; v < 11; v++) begin
            base = nreq;
            pc = tbl[v].pc;
            wait_valid(40, lat);
            chk($sformatf("v%0d_valid", v), inst_valid, 1'b1);
            chk($sformatf("v%0d_inst", v), inst, tbl[v].inst);
            chk($sformatf("v%0d_comp", v), inst_comp, tbl[v].comp);
            chk($sformatf("v%0d_reqs", v), nreq - base, tbl[v].reqs);
            chk($sformatf("v%0d_lat", v), lat, tbl[v].lat);
            if (tbl[v].reqs >= 1 && req_log.size() > base)
                chk($sformatf("v%0d_addr0", v), req_log[base], tbl[v].a0);
            if (tbl[v].reqs >= 2 && req_log.size() > base + 1)
                chk($sformatf("v%0d_addr1", v), req_log[base+1], tbl[v].a1);
        end

        // Grant back-pressure: request held stable, no valid until fill
        gnt_delay = 4;
        base = nreq;
        pc = 64'h30;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("bp_mem_req", mem_req, 1'b1);
            chk("bp_mem_addr", mem_addr, 64'h30);
            chk("bp_inst_valid", inst_valid, 1'b0);
        end
        wait_valid(40, lat);
        tot = lat + 4;
        chk("bp_inst", inst, 32'h00008082);
        chk("bp_comp", inst_comp, 1'b1);
        chk("bp_lat", tot, 7);
        chk("bp_reqs", nreq - base, 1);
        gnt_delay = 0;

        // Flush while waiting for read data: fill discarded, request re-issued
        rv_delay = 2;
        base = nreq;
        pc = 64'h40;
        @(negedge clk); #1;
        chk("fw_mem_req", mem_req, 1'b1);
        @(negedge clk); #1;
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("fw_dropped_valid", inst_valid, 1'b0);
        chk("fw_request", request, 1'b1);
        @(negedge clk); #1;
        chk("fw_reissue_req", mem_req, 1'b1);
        chk("fw_reissue_addr", mem_addr, 64'h40);
        rv_delay = 0;
        wait_valid(40, lat);
        chk("fw_inst", inst, 32'h00000013);
        chk("fw_reqs", nreq - base, 2);

        // Flush on a hit hides the instruction in that cycle and after
        flush = 1'b1;
        #1;
        chk("fh_same_cycle", inst_valid, 1'b0);
        @(negedge clk); #1;
        flush = 1'b0;
        #1;
        chk("fh_after_valid", inst_valid, 1'b0);
        chk("fh_after_request", request, 1'b1);
        wait_valid(40, lat);
        chk("fh_refill_inst", inst, 32'h00000013);

        // Asynchronous reset while in REQ
        gnt_delay = 10;
        base = nreq;
        pc = 64'h0;
        @(negedge clk); #1;
        chk("ar_mem_req_before", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mem_req_async", mem_req, 1'b0);
        chk("ar_mem_addr_async", mem_addr, 64'h0);
        repeat (2) @(negedge clk);
        gnt_delay = 0;
        pc = 64'h40;
        #1;
        rst_n = 1'b1;
        #1;
        chk("ar_buffer_invalid", inst_valid, 1'b0);
        chk("ar_request", request, 1'b1);
        wait_valid(40, lat);
        chk("ar_refill_inst", inst, 32'h00000013);
        chk("ar_reqs", nreq - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_fetch_align.md
# inst_fetch_align

Instruction-fetch responder for the PC-driven fetch stage. Takes the current `pc` from the fetch sequencer and returns a 16- or 32-bit RISC-V instruction with valid and compressed flags. It holds a 2-entry direct-mapped buffer of 64-bit memory words, indexed by `addr[3]`, and refills it over a request/grant/response memory port. It assembles instructions that straddle two 64-bit words.

## Interface
- `ADDR_W`, 64, PC / memory address width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc`  in  ADDR_W  halfword-aligned fetch address, registered by the sequencer; `pc[0]` ignored, treated as 0.
- `flush`  in  1  invalidate both buffer entries (fence.i / redirect).
- `inst_valid`  out  1  `inst` holds the complete instruction at `pc` this cycle.
- `inst_comp`  out  1  instruction is 16-bit (`inst[1:0] != 2'b11`); valid only with `inst_valid`.
- `inst`  out  32  instruction; upper 16 bits zero when compressed; all zero when `!inst_valid`.
- `request`  out  1  miss pending: FSM not IDLE, or a miss is detected this cycle.
- `mem_req`  out  1  memory read request, registered.
- `mem_addr`  out  ADDR_W  8-byte-aligned word address, registered, `[2:0]=0`.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid; at most one outstanding.
- `mem_rdata`  in  64  read data, little-endian halfwords.

## Operation
- Buffer entry e ∈ {0,1}: `vld[e]`, `tag[e] = addr[63:4]`, `data[e]` (64b). Word W lives in entry `W[3]`.
- Low word `L = {pc[63:3],3'b0}`; `hw0` = halfword `pc[2:1]` of L.
- If `pc[2:1] != 3`: hit when L is present. Instruction is `hw0`, or `{hw1,hw0}` from the same word.
- If `pc[2:1] == 3`: if `hw0` is compressed, only L is needed. Otherwise the upper half is halfword 0 of `H = L+8`, and both L and H must be present.
- `inst_valid`, `inst_comp` and `inst` are combinational from `pc` and the buffer. A hit costs zero cycles.
- Miss word selection: L if L is absent, else H.
- FSM:
  - IDLE: on a miss with no flush → REQ; load `mem_addr`, set `mem_req=1`.
  - REQ: hold `mem_req`/`mem_addr` stable until `mem_gnt`. On gnt: `mem_req=0` → WAIT.
  - WAIT: on `mem_rvalid`, write `data[mem_addr[3]]`, set `tag`/`vld` unless `drop` is set → IDLE.
- `flush`: clears both `vld` in the same edge. If the FSM is in REQ or WAIT, set `drop`; the request still completes handshake-legally and its data is discarded. `drop` clears on return to IDLE.
- A fill to an entry overwrites it unconditionally.
- Straddle with both words absent: L is filled first, then H. This takes two sequential transactions.
- `mem_gnt` or `mem_rvalid` while in the wrong state is ignored.

## Timing
- Reset values: `vld=0`, `drop=0`, FSM IDLE, `mem_req=0`, `mem_addr=0`. Outputs then read `inst_valid=0`, `inst_comp=0`, `inst=0`. `request` follows the miss logic.
- Single-word miss with gnt in the REQ cycle and rvalid one cycle later:
  - pc presented at cycle 0 (`request=1`).
  - cycle 1: `mem_req=1` and gnt.
  - cycle 2: rvalid.
  - cycle 3: `inst_valid=1`.
  - Miss latency is 3 cycles plus gnt/rvalid wait states.
- A double miss adds the same cost again for H.
- `inst_valid` never asserts in a cycle where `flush=1` and the instruction bytes were only available before that flush edge. The outputs are combinational on the post-edge state.
- A `pc` change during a miss is legal. The outstanding fill completes, and the next miss decision uses the new `pc` once back in IDLE.
- Reset asserted mid-transaction returns everything to reset values immediately. Memory is assumed reset together with this block.

## Test plan
- Reset then `pc=0`, memory word 0 = `0x0000_4501_0010_0093`: `request=1` for cycle 0; `mem_addr=0` with a single `mem_req` pulse. Then `inst_valid=1` with `inst=0x00100093`, comp=0. With `pc=4`: `inst=0x00004501`, comp=1, no new request.
- Straddle: `pc=0x6` with word0 halfword3 `0x0513`, word1 halfword0 `0x0040`, both absent. Requires two requests, `0x0` then `0x8`; then `inst=0x00400513`, comp=0.
- Compressed at offset 6 (`0x4505`) with only word0 present: `inst_valid=1`, comp=1, `inst=0x00004505`, no request for `0x8`.
- Grant back-pressure: hold `mem_gnt=0` for 4 cycles. `mem_req` and `mem_addr` must remain stable, and `inst_valid` must stay 0 until the fill completes.
- Flush in WAIT: the returned data is discarded (`vld` stays 0). `request` re-asserts and a new `mem_req` to the same address is issued.
- Async reset in REQ: `mem_req` drops to 0 immediately without waiting for a clock edge; the buffer is invalid after release.
